// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a program over an 8N1 serial line and writes it
// into the core's RAM as 32-bit words while holding the core in reset.
//
// Protocol (host to loader): ONBYTE, N[7:0], N[15:8], 4*N data bytes
// (little-endian words), then the XOR of all data bytes.
//
// Ports:
//   Clk        system clock
//   Rst        synchronous active-high reset
//   RX         asynchronous UART receive line, idle high
//   mem_we     one-cycle RAM write strobe
//   mem_addr   word address of the write
//   mem_wdata  32-bit write data
//   core_rst   holds the core in reset while high
//   boot_done  one-cycle pulse on a successful load
//   boot_err   sticky error flag, cleared by the next ONBYTE
module uart_boot_loader #(
   parameter int unsigned CLK_DIV  = 434,
   parameter logic [7:0]  ONBYTE   = 8'hAA,
   parameter int unsigned MEM_SIZE = 8192,
   parameter int unsigned ADDR_W   = $clog2(MEM_SIZE / 4)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              RX,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst,
   output logic              boot_done,
   output logic              boot_err
);

   localparam int unsigned WORDS = MEM_SIZE / 4;
   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   localparam logic [CNT_W-1:0] HalfCnt = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FullCnt = CNT_W'(CLK_DIV - 1);

   // Receiver states
   localparam logic [1:0] RxIdle  = 2'd0;
   localparam logic [1:0] RxStart = 2'd1;
   localparam logic [1:0] RxData  = 2'd2;
   localparam logic [1:0] RxStop  = 2'd3;

   // Protocol states
   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLenLo = 3'd1;
   localparam logic [2:0] StLenHi = 3'd2;
   localparam logic [2:0] StData  = 3'd3;
   localparam logic [2:0] StCsum  = 3'd4;
   localparam logic [2:0] StErr   = 3'd5;

   // ---------------------------------------------------------------------
   // UART receiver
   // ---------------------------------------------------------------------
   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   logic [1:0]       rx_st_q, rx_st_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_err_q, frame_err_d;

   always_comb begin
      rx_st_d      = rx_st_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_st_q)
         RxIdle: begin
            // Falling edge only, so a line stuck low after a framing error
            // does not retrigger.
            if (rx_prev_q && !rx_sync_q) begin
               rx_st_d  = RxStart;
               rx_cnt_d = HalfCnt;
            end
         end
         RxStart: begin
            if (rx_cnt_q == '0) begin
               if (rx_sync_q) begin
                  rx_st_d = RxIdle;  // glitch
               end else begin
                  rx_st_d  = RxData;
                  rx_cnt_d = FullCnt;
                  rx_bit_d = 3'd0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
         RxData: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_cnt_d   = FullCnt;
               if (rx_bit_q == 3'd7) rx_st_d = RxStop;
               else                  rx_bit_d = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
         default: begin  // RxStop
            if (rx_cnt_q == '0) begin
               if (rx_sync_q) byte_valid_d = 1'b1;
               else           frame_err_d  = 1'b1;
               rx_st_d = RxIdle;
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_st_q      <= RxIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= 3'd0;
         rx_shift_q   <= 8'd0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_meta_q    <= RX;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         rx_st_q      <= rx_st_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Load protocol FSM
   // ---------------------------------------------------------------------
   logic [2:0]        state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W-1:0] widx_q, widx_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [31:0]       word_q, word_d;
   logic [7:0]        csum_q, csum_d;
   logic              mem_we_d, core_rst_d, boot_done_d, boot_err_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [31:0]       mem_wdata_d;

   logic [15:0] len_full;
   logic [31:0] word_next;
   logic        last_word;

   assign len_full  = {rx_shift_q, len_q[7:0]};
   assign word_next = {rx_shift_q, word_q[31:8]};
   assign last_word = (32'(widx_q) + 32'd1) == 32'(len_q);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      widx_d      = widx_q;
      bcnt_d      = bcnt_q;
      word_d      = word_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      core_rst_d  = core_rst;
      boot_done_d = 1'b0;
      boot_err_d  = boot_err;
      case (state_q)
         StIdle: begin
            if (byte_valid_q && rx_shift_q == ONBYTE) begin
               core_rst_d = 1'b1;
               boot_err_d = 1'b0;
               csum_d     = 8'd0;
               widx_d     = '0;
               bcnt_d     = 2'd0;
               state_d    = StLenLo;
            end
         end
         StLenLo: begin
            if (byte_valid_q) begin
               len_d[7:0] = rx_shift_q;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            if (byte_valid_q) begin
               len_d = len_full;
               if (32'(len_full) > WORDS) state_d = StErr;
               else if (len_full == 16'd0) state_d = StCsum;
               else                        state_d = StData;
            end
         end
         StData: begin
            if (byte_valid_q) begin
               word_d = word_next;
               csum_d = csum_q ^ rx_shift_q;
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = widx_q;
                  mem_wdata_d = word_next;
                  widx_d      = widx_q + ADDR_W'(1);
                  if (last_word) state_d = StCsum;
               end
            end
         end
         StCsum: begin
            if (byte_valid_q) begin
               if (rx_shift_q == csum_q) begin
                  boot_done_d = 1'b1;
                  core_rst_d  = 1'b0;
                  state_d     = StIdle;
               end else begin
                  state_d = StErr;
               end
            end
         end
         default: begin  // StErr: core stays in reset until a clean load
            boot_err_d = 1'b1;
            state_d    = StIdle;
         end
      endcase
      if (frame_err_q && state_q != StIdle && state_q != StErr) state_d = StErr;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= StIdle;
         len_q     <= 16'd0;
         widx_q    <= '0;
         bcnt_q    <= 2'd0;
         word_q    <= 32'd0;
         csum_q    <= 8'd0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'd0;
         core_rst  <= 1'b0;
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         widx_q    <= widx_d;
         bcnt_q    <= bcnt_d;
         word_q    <= word_d;
         csum_q    <= csum_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         core_rst  <= core_rst_d;
         boot_done <= boot_done_d;
         boot_err  <= boot_err_d;
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: transaction-level model of the
// load protocol predicts RAM writes and final status for each download.
module tb_uart_boot_loader;

   localparam int unsigned CLK_DIV  = 16;
   localparam int unsigned MEM_SIZE = 64;
   localparam int unsigned ADDR_W   = 4;
   localparam int          CAP      = MEM_SIZE / 4;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              RX;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_rst;
   logic              boot_done;
   logic              boot_err;

   uart_boot_loader #(
      .CLK_DIV  (CLK_DIV),
      .ONBYTE   (8'hAA),
      .MEM_SIZE (MEM_SIZE),
      .ADDR_W   (ADDR_W)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .RX        (RX),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_rst  (core_rst),
      .boot_done (boot_done),
      .boot_err  (boot_err)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;
   int done_seen = 0;
   logic prev_core_rst = 1'b0;

   int          exp_addr[$];
   logic [31:0] exp_data[$];
   logic [31:0] wbuf[0:CAP-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every write and every boot_done pulse is checked against the model.
   always @(negedge Clk) begin
      if (!Rst) begin
         if (mem_we) begin
            if (exp_addr.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got addr=%0d data=%h expected no write",
                        mem_addr, mem_wdata);
            end else begin
               chk("write_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
               chk("write_data", mem_wdata, exp_data.pop_front());
               chk("core_rst_during_write", 32'(core_rst), 32'd1);
            end
         end
         if (boot_done) begin
            done_seen++;
            chk("core_rst_at_done", 32'(core_rst), 32'd0);
            chk("core_rst_before_done", 32'(prev_core_rst), 32'd1);
         end
         prev_core_rst = core_rst;
      end
   end

   task automatic bit_time(input logic v);
      RX = v;
      repeat (CLK_DIV) @(negedge Clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop);
      RX = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic glitch();
      RX = 1'b0;
      repeat (3) @(negedge Clk);
      RX = 1'b1;
      repeat (30) @(negedge Clk);
   endtask

   function automatic logic [7:0] xor_of(input int n);
      logic [7:0] x = 8'd0;
      for (int w = 0; w < n; w++) x = x ^ wbuf[w][7:0] ^ wbuf[w][15:8] ^ wbuf[w][23:16] ^ wbuf[w][31:24];
      return x;
   endfunction

   // One download of wbuf[0..n-1]. bad_stop: data byte index sent with a low
   // stop bit (-1 none). glitch_at: data byte index preceded by an RX glitch.
   task automatic run_load(input string name, input int n, input logic [7:0] csum,
                           input int bad_stop, input int glitch_at);
      bit ok;
      int nwr;
      int done0;
      logic [7:0] b;
      logic [15:0] nn;
      nn = 16'(n);
      if (n > CAP) begin
         ok = 1'b0; nwr = 0;
      end else if (bad_stop >= 0) begin
         ok = 1'b0; nwr = bad_stop / 4;
      end else begin
         ok = (csum == xor_of(n)); nwr = n;
      end
      for (int w = 0; w < nwr; w++) begin
         exp_addr.push_back(w);
         exp_data.push_back(wbuf[w]);
      end
      done0 = done_seen;
      send_byte(8'hAA, 1'b1);
      chk({name, "_core_rst_on"}, 32'(core_rst), 32'd1);
      chk({name, "_err_cleared"}, 32'(boot_err), 32'd0);
      send_byte(nn[7:0], 1'b1);
      send_byte(nn[15:8], 1'b1);
      if (n > CAP) begin
         for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
      end else begin
         for (int i = 0; i < 4 * n; i++) begin
            b = wbuf[i / 4][8 * (i % 4) +: 8];
            if (i == glitch_at) glitch();
            if (i == bad_stop) begin
               send_byte(b, 1'b0);
               break;
            end
            send_byte(b, 1'b1);
         end
         if (bad_stop < 0) send_byte(csum, 1'b1);
      end
      repeat (8) @(negedge Clk);
      chk({name, "_writes_pending"}, 32'(exp_addr.size()), 32'd0);
      chk({name, "_done_pulses"}, 32'(done_seen - done0), ok ? 32'd1 : 32'd0);
      chk({name, "_core_rst"}, 32'(core_rst), ok ? 32'd0 : 32'd1);
      chk({name, "_boot_err"}, 32'(boot_err), ok ? 32'd0 : 32'd1);
      exp_addr.delete();
      exp_data.delete();
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({name, "_core_rst"}, 32'(core_rst), 32'd0);
      chk({name, "_boot_done"}, 32'(boot_done), 32'd0);
      chk({name, "_boot_err"}, 32'(boot_err), 32'd0);
   endtask

   initial begin
      int n;
      logic [7:0] cs;
      Rst = 1'b1;
      RX  = 1'b1;
      repeat (3) @(negedge Clk);
      chk_reset_outputs("reset");
      Rst = 1'b0;
      repeat (4) @(negedge Clk);

      // Idle noise and glitch: nothing happens
      glitch();
      send_byte(8'h55, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      chk("noise_core_rst", 32'(core_rst), 32'd0);
      chk("noise_boot_err", 32'(boot_err), 32'd0);

      // Directed loads with hand-computed checksums
      wbuf[0] = 32'h0000_0013;
      wbuf[1] = 32'h0000_006F;
      run_load("valid", 2, 8'h7C, -1, -1);
      run_load("bad_csum", 2, 8'h7D, -1, -1);
      run_load("recover", 2, 8'h7C, -1, 5);  // glitch mid-data must not add a byte
      run_load("oversize", 17, 8'h00, -1, -1);
      run_load("empty", 0, 8'h00, -1, -1);
      run_load("frame_err", 2, 8'h7C, 2, -1);
      wbuf[0] = 32'hAAAA_AAAA;
      run_load("onbyte_data", 1, 8'h00, -1, -1);

      // Reset abort mid-DATA: one word lands, then everything reverts
      exp_addr.push_back(0);
      exp_data.push_back(32'h4433_2211);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      chk("abort_pre_writes", 32'(exp_addr.size()), 32'd0);
      RX = 1'b0;
      repeat (CLK_DIV) @(negedge Clk);
      Rst = 1'b1;
      RX  = 1'b1;
      @(negedge Clk);
      chk_reset_outputs("abort");
      Rst = 1'b0;
      repeat (CLK_DIV * 4) @(negedge Clk);
      send_byte(8'h13, 1'b1);  // ignored only if back in IDLE
      repeat (4) @(negedge Clk);
      chk("abort_idle_core_rst", 32'(core_rst), 32'd0);
      chk("abort_idle_boot_err", 32'(boot_err), 32'd0);

      // Full-capacity load: addresses 0..CAP-1
      for (int w = 0; w < CAP; w++) wbuf[w] = $urandom;
      run_load("full", CAP, xor_of(CAP), -1, -1);

      // Randomized loads, some with corrupted checksums
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(0, 6);
         for (int w = 0; w < n; w++) wbuf[w] = $urandom;
         cs = xor_of(n);
         if ($urandom_range(0, 2) == 0) cs = cs ^ 8'($urandom_range(1, 255));
         run_load("random", n, cs, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
